pipe_stage_elastic: RTL and testbench

Parametrised successor to the fixed ID/EX-style stage register. It carries one instruction's control and data fields between two pipeline stages using a valid/ready handshake and a 2-entry skid buffer, so stalls do not create combinational ready paths. It supports a synchronous flush that squashes in-flight entries into bubbles. It also keeps saturating stall and bubble counters for performance debug. One instance is placed at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_elastic.sv | 96 +++++++++
 tb/tb_pipe_stage_elastic.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: valid/ready handshake with a 2-entry skid
// buffer, synchronous flush, and saturating stall/bubble counters.
module pipe_stage_elastic #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic              v;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    entry_t m_q, s_q, m_n, s_n, in_e;
    logic   accept, pop;

    assign accept = in_valid & in_ready;
    assign pop    = m_q.v & out_ready;
    assign in_e   = '{v: 1'b1, ctrl: in_ctrl, data: in_data};

    // S is only ever occupied while M is, so an empty M implies an empty S.
    always_comb begin
        m_n = m_q;
        s_n = s_q;
        if (flush) begin
            m_n.v    = 1'b0;
            m_n.ctrl = '0;
            s_n.v    = 1'b0;
            s_n.ctrl = '0;
        end else if (!m_q.v) begin
            if (accept) m_n = in_e;
        end else if (pop) begin
            if (s_q.v) begin
                m_n = s_q;
                if (accept) s_n = in_e;
                else s_n.v = 1'b0;
            end else if (accept) begin
                m_n = in_e;
            end else begin
                m_n.v = 1'b0;
            end
        end else if (accept) begin
            s_n = in_e;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q      <= '0;
            s_q      <= '0;
            in_ready <= 1'b1;
        end else begin
            m_q      <= m_n;
            s_q      <= s_n;
            in_ready <= !s_n.v;
        end
    end

    assign out_valid = m_q.v;
    assign out_ctrl  = m_q.v ? m_q.ctrl : '0;
    assign out_data  = m_q.data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (m_q.v && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (!m_q.v && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed testbench for pipe_stage_elastic: fill/drain, streaming, flush,
// counter saturation/clear and asynchronous reset.
module tb_pipe_stage_elastic;

    localparam int DATA_W = 128;
    localparam int CTRL_W = 24;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              cnt_clr;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_elastic #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        checks++;
        if (out_ctrl !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_bus: ctrl=%h data=%h want 0", out_ctrl, out_data);
        end
        checks++;
        if (stall_cnt !== '0 || bubble_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt: stall=%0d bubble=%0d want 0 0", stall_cnt, bubble_cnt);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_fill_hold();
        out_ready = 1'b0;
        cnt_clr   = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 24'h000011;
        in_data   = 128'h11;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 128'h11 || out_ctrl !== 24'h11 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_a: v=%b d=%h c=%h rdy=%b want 1 11 11 1", out_valid, out_data, out_ctrl, in_ready);
        end
        cnt_clr = 1'b0;
        in_ctrl = 24'h000022;
        in_data = 128'h22;
        step();
        checks++;
        if (in_ready !== 1'b0 || out_data !== 128'h11 || stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL fill_b: rdy=%b d=%h stall=%0d want 0 11 1", in_ready, out_data, stall_cnt);
        end
        in_ctrl = 24'h000033;
        in_data = 128'h33;
        step();
        checks++;
        if (in_ready !== 1'b0 || out_data !== 128'h11 || stall_cnt !== 4'd2) begin
            errors++;
            $display("FAIL hold_1: rdy=%b d=%h stall=%0d want 0 11 2", in_ready, out_data, stall_cnt);
        end
        step();
        checks++;
        if (in_ready !== 1'b0 || out_data !== 128'h11 || stall_cnt !== 4'd3) begin
            errors++;
            $display("FAIL hold_2: rdy=%b d=%h stall=%0d want 0 11 3", in_ready, out_data, stall_cnt);
        end
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 128'h22 || in_ready !== 1'b1 || stall_cnt !== 4'd3) begin
            errors++;
            $display("FAIL drain_b: v=%b d=%h rdy=%b stall=%0d want 1 22 1 3", out_valid, out_data, in_ready, stall_cnt);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 128'h33 || out_ctrl !== 24'h33) begin
            errors++;
            $display("FAIL drain_c: v=%b d=%h c=%h want 1 33 33", out_valid, out_data, out_ctrl);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: v=%b c=%h rdy=%b want 0 0 1", out_valid, out_ctrl, in_ready);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            cnt_clr = (i == 1);
            in_data = DATA_W'(i);
            in_ctrl = CTRL_W'(i);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== DATA_W'(i) || out_ctrl !== CTRL_W'(i)) begin
                errors++;
                $display("FAIL stream_%0d: v=%b d=%0d c=%0d want 1 %0d", i, out_valid, out_data, out_ctrl, i);
            end
        end
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (bubble_cnt !== 4'd0 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL stream_cnt: bubble=%0d stall=%0d want 0 0", bubble_cnt, stall_cnt);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            errors++;
            $display("FAIL stream_end: v=%b c=%h want 0 0", out_valid, out_ctrl);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 24'hFFFFFF;
        in_data   = 128'hA1;
        step();
        in_data = 128'hA2;
        step();
        checks++;
        if (in_ready !== 1'b0 || out_data !== 128'hA1) begin
            errors++;
            $display("FAIL flush_pre: rdy=%b d=%h want 0 a1", in_ready, out_data);
        end
        flush   = 1'b1;
        in_data = 128'hA3;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: v=%b c=%h rdy=%b want 0 0 1", out_valid, out_ctrl, in_ready);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            errors++;
            $display("FAIL flush_gone: v=%b c=%h want 0 0", out_valid, out_ctrl);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'hB1;
        step();
        flush   = 1'b1;
        in_data = 128'hB2;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_acc: v=%b c=%h rdy=%b want 0 0 1", out_valid, out_ctrl, in_ready);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_acc_gone: v=%b d=%h want 0", out_valid, out_data);
        end
    endtask

    task automatic test_sat_clear();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b1;
        step();
        cnt_clr = 1'b0;
        checks++;
        if (bubble_cnt !== 4'd0) begin
            errors++;
            $display("FAIL sat_clr0: bubble=%0d want 0", bubble_cnt);
        end
        repeat (20) step();
        checks++;
        if (bubble_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_20: bubble=%0d want 15", bubble_cnt);
        end
        step();
        checks++;
        if (bubble_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold: bubble=%0d want 15", bubble_cnt);
        end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        checks++;
        if (bubble_cnt !== 4'd0) begin
            errors++;
            $display("FAIL clr: bubble=%0d want 0", bubble_cnt);
        end
        step();
        checks++;
        if (bubble_cnt !== 4'd1) begin
            errors++;
            $display("FAIL clr_resume: bubble=%0d want 1", bubble_cnt);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 24'h000005;
        in_data   = 128'h5;
        step();
        in_ctrl = 24'h000006;
        in_data = 128'h6;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 128'h6) begin
            errors++;
            $display("FAIL ar_pre: v=%b d=%h want 1 6", out_valid, out_data);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL ar_now: v=%b rdy=%b c=%h d=%h want 0 1 0 0", out_valid, in_ready, out_ctrl, out_data);
        end
        checks++;
        if (stall_cnt !== '0 || bubble_cnt !== '0) begin
            errors++;
            $display("FAIL ar_cnt: stall=%0d bubble=%0d want 0 0", stall_cnt, bubble_cnt);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_held: v=%b want 0", out_valid);
        end
        #3;
        reset   = 1'b1;
        in_ctrl = 24'h000077;
        in_data = 128'h77;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 128'h77 || out_ctrl !== 24'h77) begin
            errors++;
            $display("FAIL ar_first: v=%b d=%h c=%h want 1 77 77", out_valid, out_data, out_ctrl);
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_fill_hold();
        test_drain();
        test_stream();
        test_flush();
        test_sat_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
